// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: requester and CoreI2C master signals shared by the arbiter and its environment.
interface i2c_req_arbiter_if;
  logic [1:0]  req_i;
  logic [15:0] req_cmd0_i;
  logic [15:0] req_cmd1_i;
  logic [1:0]  gnt_o;
  logic [1:0]  done_o;
  logic [1:0]  status_o;
  logic [7:0]  rdata_o;
  logic        m_start_o;
  logic [15:0] m_cmd_o;
  logic        m_abort_o;
  logic        m_busy_i;
  logic        m_done_i;
  logic        m_nack_i;
  logic [7:0]  m_rdata_i;
  modport slave (
    input  req_i, req_cmd0_i, req_cmd1_i, m_busy_i, m_done_i, m_nack_i, m_rdata_i,
    output gnt_o, done_o, status_o, rdata_o, m_start_o, m_cmd_o, m_abort_o
  );
  modport master (
    output req_i, req_cmd0_i, req_cmd1_i, m_busy_i, m_done_i, m_nack_i, m_rdata_i,
    input  gnt_o, done_o, status_o, rdata_o, m_start_o, m_cmd_o, m_abort_o
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C master between two requesters.
// Define I2C_ARB_TIMEOUT_EN to build the watchdog, the ABORT state and m_abort_o.
module i2c_req_arbiter #(
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input logic FAB_CCC_GL0,
  input logic FAB_RESET_N,
  i2c_req_arbiter_if.slave bus
);
  if (TIMEOUT < 2 || 64'(TIMEOUT) >= (64'd1 << TO_W)) begin : g_bad_cfg
    $error("TIMEOUT must be >= 2 and < 2**TO_W");
  end
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
`ifdef I2C_ARB_TIMEOUT_EN
    ABORT,
`endif
    COMPLETE
  } state_t;
  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic [15:0] cmd_q, cmd_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        start, abort;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
`endif
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cmd_d    = cmd_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    start    = 1'b0;
    abort    = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    to_d     = to_q;
`endif
    case (state_q)
      IDLE: if (|bus.req_i) begin
        // On a tie the requester that was not served last wins.
        win_d   = (bus.req_i == 2'b11) ? ~win_q : bus.req_i[1];
        cmd_d   = win_d ? bus.req_cmd1_i : bus.req_cmd0_i;
        state_d = ISSUE;
      end
      ISSUE: if (!bus.m_busy_i) begin
        start   = 1'b1;
        state_d = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      WAIT: if (bus.m_done_i) begin
        status_d = {1'b0, bus.m_nack_i};
        rdata_d  = (cmd_q[8] && !bus.m_nack_i) ? bus.m_rdata_i : rdata_q;
        state_d  = COMPLETE;
      end
`ifdef I2C_ARB_TIMEOUT_EN
      else if (to_q == TO_W'(TIMEOUT - 1)) begin
        abort   = 1'b1;
        state_d = ABORT;
      end else begin
        to_d = to_q + 1'b1;
      end
      ABORT: if (!bus.m_busy_i) begin
        status_d = 2'b10;
        state_d  = COMPLETE;
      end
`endif
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      state_q  <= IDLE;
      win_q    <= 1'b1;
      cmd_q    <= '0;
      status_q <= '0;
      rdata_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cmd_q    <= cmd_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end
  assign bus.gnt_o     = (state_q == IDLE) ? 2'b00 : (win_q ? 2'b10 : 2'b01);
  assign bus.done_o    = (state_q == COMPLETE) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.status_o  = status_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.m_cmd_o   = cmd_q;
  assign bus.m_start_o = start;
  assign bus.m_abort_o = abort;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: directed literal checks plus randomized traffic against a transaction-level model.
module tb_i2c_req_arbiter;
  localparam int TMO = 100;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  i2c_req_arbiter_if bus();
  i2c_req_arbiter #(.TO_W(16), .TIMEOUT(TMO)) dut (
    .FAB_CCC_GL0(clk),
    .FAB_RESET_N(rst_n),
    .bus(bus)
  );
  int tests = 0;
  int fails = 0;
  task automatic chk(string n, logic [15:0] got, logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int pick(logic [1:0] r, int l);
    return (r == 2'b11) ? 1 - l : int'(r[1]);
  endfunction
  // Transaction model: an active transfer is granted, started, then finished by master done or watchdog.
  bit act, started, aborting, report;
  int owner, last, tstart, cyc;
  logic [15:0] mcmd;
  logic [1:0]  st;
  logic [7:0]  rd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= 0; started <= 0; aborting <= 0; report <= 0;
      owner <= 0; last <= 1; tstart <= 0; cyc <= 0;
      mcmd <= '0; st <= '0; rd <= '0;
    end else begin
      cyc <= cyc + 1;
      if (report) begin
        report <= 0; act <= 0; last <= owner;
      end else if (!act) begin
        if (bus.req_i != 2'b00) begin
          owner <= pick(bus.req_i, last);
          mcmd <= pick(bus.req_i, last) == 1 ? bus.req_cmd1_i : bus.req_cmd0_i;
          act <= 1; started <= 0; aborting <= 0;
        end
      end else if (!started) begin
        if (!bus.m_busy_i) begin started <= 1; tstart <= cyc; end
      end else if (aborting) begin
        if (!bus.m_busy_i) begin st <= 2'b10; report <= 1; end
      end else if (bus.m_done_i) begin
        st <= {1'b0, bus.m_nack_i};
        if (mcmd[8] && !bus.m_nack_i) rd <= bus.m_rdata_i;
        report <= 1;
      end else if (TO_EN && cyc == tstart + TMO) begin
        aborting <= 1;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt", 16'(bus.gnt_o), act ? 16'(1 << owner) : 16'd0);
      chk("done", 16'(bus.done_o), report ? 16'(1 << owner) : 16'd0);
      chk("start", 16'(bus.m_start_o), 16'(act && !started && !bus.m_busy_i));
      chk("abort", 16'(bus.m_abort_o),
          16'(TO_EN && act && started && !aborting && !report && !bus.m_done_i && cyc == tstart + TMO));
      chk("cmd", bus.m_cmd_o, mcmd);
      chk("status", 16'(bus.status_o), 16'(st));
      chk("rdata", 16'(bus.rdata_o), 16'(rd));
    end
  end
  initial begin
    int n;
    bus.req_i = 0; bus.req_cmd0_i = 0; bus.req_cmd1_i = 0;
    bus.m_busy_i = 0; bus.m_done_i = 0; bus.m_nack_i = 0; bus.m_rdata_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 16'(bus.gnt_o), 16'd0);
    chk("rst_done", 16'(bus.done_o), 16'd0);
    chk("rst_start", 16'(bus.m_start_o), 16'd0);
    chk("rst_cmd", bus.m_cmd_o, 16'd0);
    tick(); rst_n = 1;
    // single write
    tick(); bus.req_i = 2'b01; bus.req_cmd0_i = 16'hA055;
    tick(); bus.req_i = 2'b00; bus.req_cmd0_i = 16'h1111;
    @(negedge clk);
    chk("wr_gnt", 16'(bus.gnt_o), 16'h0001);
    chk("wr_start", 16'(bus.m_start_o), 16'h0001);
    chk("wr_cmd", bus.m_cmd_o, 16'hA055);
    repeat (19) tick();
    bus.m_done_i = 1; bus.m_nack_i = 0; bus.m_rdata_i = 8'h99;
    tick(); bus.m_done_i = 0;
    @(negedge clk);
    chk("wr_done", 16'(bus.done_o), 16'h0001);
    chk("wr_status", 16'(bus.status_o), 16'h0000);
    chk("wr_rdata", 16'(bus.rdata_o), 16'h0000);
    tick();
    // busy master holds off the start pulse
    bus.req_i = 2'b01; bus.m_busy_i = 1;
    tick(); bus.req_i = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0 || i == 9) chk("busy_hold", 16'(bus.m_start_o), 16'h0000);
      tick();
    end
    bus.m_busy_i = 0;
    @(negedge clk);
    chk("busy_start", 16'(bus.m_start_o), 16'h0001);
    tick();
    @(negedge clk);
    chk("busy_single", 16'(bus.m_start_o), 16'h0000);
    bus.m_done_i = 1;
    tick(); bus.m_done_i = 0;
    tick();
`ifdef I2C_ARB_TIMEOUT_EN
    // watchdog expiry while the master stays busy
    bus.req_i = 2'b01;
    tick(); bus.req_i = 2'b00;
    tick(); bus.m_busy_i = 1; n = 1;
    while (bus.m_abort_o !== 1'b1 && n < 2 * TMO) begin tick(); n++; end
    chk("to_abort_cycle", 16'(n), 16'(TMO));
    repeat (4) tick();
    bus.m_busy_i = 0;
    tick();
    @(negedge clk);
    chk("to_done", 16'(bus.done_o), 16'h0001);
    chk("to_status", 16'(bus.status_o), 16'h0002);
    tick();
    // done arriving in the expiry cycle wins
    bus.req_i = 2'b01;
    tick(); bus.req_i = 2'b00;
    repeat (TMO) tick();
    bus.m_done_i = 1; bus.m_nack_i = 0;
    @(negedge clk);
    chk("to_race_abort", 16'(bus.m_abort_o), 16'h0000);
    tick(); bus.m_done_i = 0;
    @(negedge clk);
    chk("to_race_done", 16'(bus.done_o), 16'h0001);
    chk("to_race_status", 16'(bus.status_o), 16'h0000);
    tick();
`endif
    // read then NACKed write from requester 1
    bus.req_i = 2'b10; bus.req_cmd1_i = 16'h7900;
    tick(); bus.req_i = 2'b00;
    tick(); bus.m_done_i = 1; bus.m_nack_i = 0; bus.m_rdata_i = 8'hA7;
    tick(); bus.m_done_i = 0;
    @(negedge clk);
    chk("rd_done", 16'(bus.done_o), 16'h0002);
    chk("rd_status", 16'(bus.status_o), 16'h0000);
    chk("rd_rdata", 16'(bus.rdata_o), 16'h00A7);
    tick();
    bus.req_i = 2'b10; bus.req_cmd1_i = 16'h7855;
    tick(); bus.req_i = 2'b00;
    tick(); bus.m_done_i = 1; bus.m_nack_i = 1; bus.m_rdata_i = 8'hFF;
    tick(); bus.m_done_i = 0; bus.m_nack_i = 0;
    @(negedge clk);
    chk("nack_status", 16'(bus.status_o), 16'h0001);
    chk("nack_rdata", 16'(bus.rdata_o), 16'h00A7);
    tick();
    // asynchronous reset in the middle of WAIT
    bus.req_i = 2'b10; bus.req_cmd1_i = 16'h1234;
    tick(); bus.req_i = 2'b00;
    tick();
    #2 rst_n = 0;
    #1;
    chk("arst_gnt", 16'(bus.gnt_o), 16'h0000);
    chk("arst_cmd", bus.m_cmd_o, 16'h0000);
    chk("arst_status", 16'(bus.status_o), 16'h0000);
    chk("arst_rdata", 16'(bus.rdata_o), 16'h0000);
    chk("arst_pulses", {14'd0, bus.m_start_o, bus.m_abort_o}, 16'h0000);
    tick(); rst_n = 1;
    // contention alternates, requester 0 first after reset
    tick(); bus.req_i = 2'b11; bus.req_cmd0_i = 16'h0A0A; bus.req_cmd1_i = 16'hB0B0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("contend_gnt", 16'(bus.gnt_o), (k % 2 == 0) ? 16'h0001 : 16'h0002);
      tick(); bus.m_done_i = 1;
      tick(); bus.m_done_i = 0;
      if (k == 3) bus.req_i = 2'b00;
      tick();
    end
    // randomized traffic, with phases of no/rare/frequent master completion
    for (int b = 0; b < 9; b++) begin
      int dp;
      dp = (b % 3 == 0) ? 0 : ((b % 3 == 1) ? 4 : 25);
      if (b == 5) begin #2 rst_n = 0; tick(); rst_n = 1; end
      for (int i = 0; i < 400; i++) begin
        tick();
        bus.req_i      = 2'($urandom_range(0, 3));
        bus.req_cmd0_i = 16'($urandom);
        bus.req_cmd1_i = 16'($urandom);
        bus.m_busy_i   = ($urandom_range(0, 99) < 30);
        bus.m_done_i   = ($urandom_range(0, 99) < dp);
        bus.m_nack_i   = ($urandom_range(0, 3) == 0);
        bus.m_rdata_i  = 8'($urandom);
      end
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Shares the single fabric I2C master (CoreI2C instance in the MSS_sys_i2c subsystem) between two fabric requesters. Each requester posts a one-byte command (7-bit slave address, R/W, write data); the arbiter grants round-robin, issues the command to the master, waits for completion and returns status and read data to the winner. An optional watchdog aborts hung transfers, for example when a slave stretches SCL indefinitely.

## Interface
Parameters:
- TO_W, 16: width of the watchdog counter.
- TIMEOUT, 50000: watchdog limit in clock cycles; must be < 2^TO_W and ≥ 2.

Ports:
- FAB_CCC_GL0  in  1  fabric clock; all logic on the rising edge.
- FAB_RESET_N  in  1  reset, asynchronous, active-low.
- req_i  in  2  level request per requester; bit n belongs to requester n.
- req_cmd0_i  in  16  requester 0 command {addr[6:0], rw, wdata[7:0]}; rw=1 means read.
- req_cmd1_i  in  16  requester 1 command, same format.
- gnt_o  out  2  one-hot grant, held from ISSUE through COMPLETE.
- done_o  out  2  one-cycle completion pulse to the granted requester.
- status_o  out  2  result: 00 ok, 01 NACK, 10 timeout; valid while done_o≠0, held afterwards.
- rdata_o  out  8  read data; valid with done_o, held afterwards.
- m_start_o  out  1  one-cycle start pulse to the master.
- m_cmd_o  out  16  latched command, stable from ISSUE until the next grant.
- m_abort_o  out  1  one-cycle abort pulse (STOP/reset request) to the master.
- m_busy_i  in  1  master busy.
- m_done_i  in  1  one-cycle transfer-complete pulse from the master.
- m_nack_i  in  1  NACK flag, qualified by m_done_i.
- m_rdata_i  in  8  read byte, qualified by m_done_i.

## Operation
- States: IDLE, ISSUE, WAIT, ABORT, COMPLETE.
- IDLE, arbitration:
  - If any req_i bit is set, select the winner. With one request, that requester wins. With both, the requester not granted last wins.
  - Latch the winner's command into m_cmd_o, set gnt_o, go to ISSUE.
- ISSUE:
  - If m_busy_i=0, pulse m_start_o and go to WAIT.
  - Otherwise stay in ISSUE without pulsing.
- WAIT:
  - On m_done_i, capture m_nack_i into status (01 on NACK, 00 otherwise) and m_rdata_i into rdata_o, then go to COMPLETE.
  - On watchdog expiry (see Configuration), pulse m_abort_o and go to ABORT.
- ABORT:
  - Wait for m_busy_i=0, then set status 10 and go to COMPLETE.
  - m_done_i is ignored in this state.
- COMPLETE:
  - Pulse done_o[winner] for one cycle.
  - Record the winner as last-granted, clear gnt_o, return to IDLE.
- Requests:
  - req_i and the command need only be valid during the IDLE arbitration cycle.
  - Deasserting req_i mid-transaction has no effect; the transfer finishes and done_o still pulses.
  - A requester holding req_i high after done_o is re-arbitrated. It wins again only if the other requester is idle.
- rdata_o is updated only on non-NACK reads. On writes, NACK or timeout it keeps its previous value.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Last-granted pointer = requester 1, so requester 0 wins the first tie.
  - Watchdog 0.
- Latency, uncontended with the master idle:
  - req_i sampled in cycle 0, gnt_o and m_cmd_o valid in cycle 1.
  - m_start_o in cycle 1.
  - done_o one cycle after the state sees m_done_i.
- Minimum spacing between transactions: IDLE→ISSUE→WAIT→COMPLETE→IDLE, so at least 4 cycles plus master time.
- Watchdog:
  - Cleared on entry to WAIT; increments each WAIT cycle.
  - Expires on the cycle its count reaches TIMEOUT-1, so m_abort_o fires exactly TIMEOUT cycles after WAIT entry.
  - If m_done_i arrives in the expiry cycle, done wins: normal completion, no abort.
- Reset asserted mid-transfer: all outputs clear immediately and asynchronously, and m_start_o/m_abort_o are never left high. The master is expected to be reset by the same signal.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - Watchdog counter, the ABORT state and the m_abort_o pulse are built.
  - status 10 is reachable.
- I2C_ARB_TIMEOUT_EN undefined:
  - No counter and no ABORT state; WAIT waits indefinitely for m_done_i.
  - m_abort_o is tied to 0; status 10 never occurs.
  - TIMEOUT and TO_W are ignored.

## Test plan
- Single write: req_i=01, cmd0=0x A055 (addr 0x50, write, data 0x55); master done without NACK after 20 cycles -> gnt_o=01 at cycle 1, m_start_o pulse at cycle 1, done_o=01 one cycle after m_done_i, status 00, rdata_o unchanged.
- Contention: req_i=11 held for 4 transactions -> grants alternate 01,10,01,10, starting with 01 after reset.
- Read plus NACK: requester 1 reads addr 0x3C, returns rdata 0xA7 -> rdata_o=A7, status 00. Then a write that returns a NACK -> status 01, rdata_o stays A7.
- Busy master: m_busy_i=1 for 10 cycles after grant -> m_start_o held off, then a single pulse in the first cycle with m_busy_i=0.
- Timeout (macro on, TIMEOUT=100): m_done_i never arrives -> m_abort_o exactly 100 cycles after WAIT entry, done_o after m_busy_i falls, status 10. A second run with m_done_i in the expiry cycle -> status 00 and no abort.
- Reset mid-WAIT: assert FAB_RESET_N=0 -> all outputs 0 asynchronously. After release, a tie goes to requester 0.
